// File: rtl/hilo_muldiv.sv
`timescale 1ns/1ps
// hilo_muldiv: iterative multiply/divide unit that owns the HI/LO registers.
//
// Executes mult/multu with a shift-add loop and div/divu with a restoring
// shift-subtract loop. Each loop retires one bit per cycle over WIDTH cycles,
// followed by one FIX cycle. The FIX cycle applies the signs and writes HI/LO.
// mthi/mtlo write HI/LO directly on the issue edge when the unit is idle.
//
// Ports:
//   CLK       system clock, rising edge
//   RESET     asynchronous active-low reset
//   start     issue strobe from decode, qualified by funct
//   funct     R-format funct field selecting the operation
//   rs_data   operand A (multiplicand / dividend / mthi-mtlo source)
//   rt_data   operand B (multiplier / divisor)
//   hilo_sel  read select: 10 = HI, 01 = LO, otherwise none
//   hilo_out  combinational HI/LO read data (0 when nothing is selected)
//   busy      high while a mult/div is in flight
//   done      one-cycle pulse in the cycle where the new HI/LO is visible
//   stall     holds decode while busy and decode wants this unit
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [1:0]       hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo;

    // Iteration datapath: acc_hi is the partial product high half / partial
    // remainder, acc_lo the multiplier / dividend being shifted out while
    // product bits / quotient bits are shifted in, opb the fixed operand.
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic             neg_p;    // negate product or quotient in FIX
    logic             neg_r;    // negate remainder in FIX
    logic             div0;     // divisor captured as zero
    logic             is_div;

    // Conditional two's-complement negation at both result widths.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Operation decode
    logic is_mul_op, is_div_op, is_signed_op, is_mthi, is_mtlo;
    logic sign_a, sign_b, last_iter;

    assign is_mul_op    = (funct == F_MULT) || (funct == F_MULTU);
    assign is_div_op    = (funct == F_DIV)  || (funct == F_DIVU);
    assign is_signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign is_mthi      = (funct == F_MTHI);
    assign is_mtlo      = (funct == F_MTLO);
    assign sign_a       = is_signed_op & rs_data[WIDTH-1];
    assign sign_b       = is_signed_op & rt_data[WIDTH-1];
    assign last_iter    = (cnt == CW'(WIDTH - 1));

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole {acc_hi, acc_lo} pair right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;

    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign mul_hi_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // One restoring-divide step. The partial remainder always stays below
    // the divisor, so the top bit of diff is a reliable borrow flag.
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_hi_nxt, div_lo_nxt;

    assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, opb};
    assign div_hi_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_lo_nxt = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};

    // FIX-cycle results. Divide by zero leaves the dividend as remainder
    // (sign restored -> original rs) and forces an all-ones quotient.
    // The -2^(W-1) / -1 case needs no special handling: the magnitude
    // quotient 2^(W-1) with a positive sign already reads as 0x80..0.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = cond_neg2({acc_hi, acc_lo}, neg_p);
    assign quo_fix  = div0 ? '1 : cond_neg(acc_lo, neg_p);
    assign rem_fix  = cond_neg(acc_hi, neg_r);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && is_mul_op)      next_state = MUL;
                else if (start && is_div_op) next_state = DIV;
            end
            MUL:     if (last_iter) next_state = FIX;
            DIV:     if (last_iter) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (state == FIX);

            if ((state == MUL) || (state == DIV))
                cnt <= last_iter ? '0 : cnt + CW'(1);
            else
                cnt <= '0;

            if (state == IDLE && start && is_mthi) hi <= rs_data;
            if (state == IDLE && start && is_mtlo) lo <= rs_data;

            if (state == FIX) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    // Datapath registers carry no reset; they are always loaded at capture
    // before any use, and reset abandons the operation via the state register.
    always_ff @(posedge CLK) begin
        if (state == IDLE && start && (is_mul_op || is_div_op)) begin
            acc_hi <= '0;
            neg_p  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            div0   <= (rt_data == '0);
            is_div <= is_div_op;
            if (is_mul_op) begin
                acc_lo <= cond_neg(rt_data, sign_b);
                opb    <= cond_neg(rs_data, sign_a);
            end else begin
                acc_lo <= cond_neg(rs_data, sign_a);
                opb    <= cond_neg(rt_data, sign_b);
            end
        end else if (state == MUL) begin
            acc_hi <= mul_hi_nxt;
            acc_lo <= mul_lo_nxt;
        end else if (state == DIV) begin
            acc_hi <= div_hi_nxt;
            acc_lo <= div_lo_nxt;
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | (hilo_sel != 2'b00));

    always_comb begin
        hilo_out = '0;
        if (hilo_sel == 2'b10)      hilo_out = hi;
        else if (hilo_sel == 2'b01) hilo_out = lo;
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
`timescale 1ns/1ps
// Testbench for hilo_muldiv: directed corner cases plus a randomized mix of
// operations, all compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv;

    localparam int WIDTH = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              start = 1'b0;
    logic [5:0]        funct = '0;
    logic [WIDTH-1:0]  rs_data = '0;
    logic [WIDTH-1:0]  rt_data = '0;
    logic [1:0]        hilo_sel = '0;
    logic [WIDTH-1:0]  hilo_out;
    logic              busy, done, stall;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .funct    (funct),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hilo_sel (hilo_sel),
        .hilo_out (hilo_out),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: architectural result {HI, LO} from ordinary 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (f)
            F_MULT:  p = sa * sb;
            F_MULTU: p = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
            default: p = {m_hi, m_lo};
        endcase
        return p;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        logic [1:0] keep;
        keep = hilo_sel;
        hilo_sel = 2'b10; #1 h = hilo_out;
        hilo_sel = 2'b01; #1 l = hilo_out;
        hilo_sel = keep;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] h, l;
        read_hilo(h, l);
        check({tag, "_hi"}, h, m_hi);
        check({tag, "_lo"}, l, m_lo);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue a mult/div, scramble operands afterwards, optionally poke the
    // unit with a read and a second start while it is busy.
    task automatic run_long(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input bit hazard);
        logic [63:0] e;
        logic [31:0] old_lo;
        int cyc;
        int done_early;
        e = ref_op(f, a, b);
        old_lo = m_lo;
        check({tag, "_idle"}, busy, 0);
        funct = f; rs_data = a; rt_data = b; start = 1'b1;
        tick();
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        cyc = 0;
        done_early = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (done) done_early++;
            if (hazard && cyc == 3) begin
                hilo_sel = 2'b01; start = 1'b1; funct = F_MULT;
                rs_data = $urandom; rt_data = $urandom;
                #1;
                check({tag, "_stall_busy"}, stall, 1);
                check({tag, "_old_lo"}, hilo_out, old_lo);
            end else if (hazard && cyc == 4) begin
                hilo_sel = 2'b00; start = 1'b0;
                #1;
                check({tag, "_stall_quiet"}, stall, 0);
            end
            tick();
        end
        check({tag, "_busy_cycles"}, cyc, WIDTH + 1);
        check({tag, "_done_early"}, done_early, 0);
        check({tag, "_done"}, done, 1);
        m_hi = e[63:32];
        m_lo = e[31:0];
        check_model(tag);
        tick();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic run_mt(input string tag, input logic [5:0] f, input logic [31:0] a);
        funct = f; rs_data = a; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        if (f == F_MTHI) m_hi = a;
        else             m_lo = a;
        check_model(tag);
    endtask

    task automatic run_bad(input string tag, input logic [5:0] f);
        funct = f; rs_data = $urandom; rt_data = $urandom; start = 1'b1;
        hilo_sel = 2'($urandom_range(0, 3));
        #1;
        check({tag, "_stall_idle"}, stall, 0);
        tick();
        start = 1'b0; hilo_sel = 2'b00;
        check({tag, "_busy"}, busy, 0);
        check_model(tag);
    endtask

    initial begin
        logic [5:0] bad_list [4];
        bad_list[0] = 6'b010000;
        bad_list[1] = 6'b010010;
        bad_list[2] = 6'b011100;
        bad_list[3] = 6'b100001;

        // Reset state
        RESET = 1'b0;
        tick(); tick();
        RESET = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_none_sel", hilo_out, 0);
        check_model("rst");

        // Directed arithmetic
        run_long("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi_const", m_hi, 32'hFFFF_FFFE);
        run_long("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg_lo_const", m_lo, 32'hFFFF_FFEB);
        run_long("div_mixed", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_mixed_hi_const", m_hi, 32'hFFFF_FFFF);
        run_long("divu", F_DIVU, 32'd100, 32'd7, 1'b0);
        check("divu_lo_const", m_lo, 32'd14);
        run_long("div_zero", F_DIV, 32'h1234_5678, 32'h0, 1'b0);
        check("div_zero_hi_const", m_hi, 32'h1234_5678);
        run_long("divu_zero", F_DIVU, 32'h8765_4321, 32'h0, 1'b0);
        run_long("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_const", m_lo, 32'h8000_0000);

        // Move-to and hazards
        run_mt("mtlo", F_MTLO, 32'hA5A5_A5A5);
        run_mt("mthi", F_MTHI, 32'h5A5A_0F0F);
        run_long("hazard", F_MULTU, 32'h0001_0003, 32'h0002_0005, 1'b1);
        run_bad("bad", 6'b100000);

        // Reset abandoning a multiply at cycle 10
        funct = F_MULT; rs_data = 32'd12345; rt_data = 32'd678; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("rst_mid_busy_before", busy, 1);
        RESET = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        m_hi = '0; m_lo = '0;
        check_model("rst_mid");
        RESET = 1'b1;
        tick();
        check("rst_mid_busy_after", busy, 0);
        hilo_sel = 2'b01; #1;
        check("rst_mid_mflo", hilo_out, 0);
        hilo_sel = 2'b00;
        tick();
        check("rst_mid_still_idle", busy, 0);

        // Randomized mix
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 6))
                0: run_long("r_mult",  F_MULT,  rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
                1: run_long("r_multu", F_MULTU, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
                2: run_long("r_div",   F_DIV,   rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
                3: run_long("r_divu",  F_DIVU,  rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
                4: run_mt("r_mthi", F_MTHI, $urandom);
                5: run_mt("r_mtlo", F_MTLO, $urandom);
                default: run_bad("r_bad", bad_list[$urandom_range(0, 3)]);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the instruction decoder.
- Executes mult, multu, div and divu, which the decoder issues with RegWrite=0. Also executes mthi and mtlo.
- Serves mfhi/mflo through the decoder's 2-bit HiLo select.
- Raises a stall to the datapath while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe from the decode stage, qualified by funct.
- funct  input  6  R-format funct: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
- rs_data  input  WIDTH  operand A (multiplicand/dividend, or mthi/mtlo source).
- rt_data  input  WIDTH  operand B (multiplier/divisor).
- hilo_sel  input  2  decoder HiLo select: 10 = HI, 01 = LO, 00/11 = none.
- hilo_out  output  WIDTH  combinational read: HI if hilo_sel=10, LO if 01, else 0.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse when HI/LO have just been updated by mult/div.
- stall  output  1  equals busy AND (start OR hilo_sel != 00).

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, HI=0, LO=0, busy=0, done=0, iteration counter=0.
  - Any in-flight operation is abandoned. HI/LO are not written by it.
- States: IDLE, MUL, DIV, FIX.
  - IDLE → MUL: on start with mult/multu.
  - IDLE → DIV: on start with div/divu.
  - MUL/DIV → FIX: after WIDTH iterations (counter from 0 to WIDTH-1).
  - FIX → IDLE: HI/LO written on this edge; done registered high for the next cycle.
- Latency, with start sampled at edge 0:
  - busy is high for cycles 1..WIDTH+1, i.e. WIDTH+1 cycles.
  - New HI/LO are visible and done=1 in cycle WIDTH+2.
  - busy=0 in that cycle, so a new start can be accepted there.
- Operand capture: rs_data/rt_data are latched at the start edge. Later changes have no effect.
- Signed ops (mult, div):
  - Operands are converted to magnitudes at capture.
  - FIX negates the result. The product sign is the XOR of the operand signs. The quotient sign is the XOR of the operand signs. The remainder takes the dividend sign.
  - Division truncates toward zero.
- mult/multu: the 2*WIDTH-bit product goes to {HI, LO}. Shift-add uses one multiplier bit per cycle.
- div/divu:
  - LO=quotient, HI=remainder.
  - Restoring shift-subtract, one quotient bit per cycle.
- Divide by zero: no exception, same latency. LO=all ones, HI=rs_data as captured (unsigned and signed alike).
- Signed overflow, -2^(WIDTH-1) / -1: LO=0x80000000 (for WIDTH=32), HI=0.
- mthi/mtlo:
  - Accepted only in IDLE. HI or LO is written with rs_data on the start edge.
  - busy stays 0 and done stays 0.
- Start while busy:
  - Ignored. stall holds the decode stage, so the instruction is re-presented.
  - The in-flight operation is unaffected.
- Start with an unlisted funct: ignored and no state change. stall still follows its equation.
- hilo_out while busy: returns the old HI/LO value. stall is asserted so the core does not consume it.
- mfhi/mflo in the done cycle: returns the new value.

Test Plan:
- Reset: RESET low mid-MUL (cycle 10) → busy=0, done=0, HI=LO=0 immediately. A subsequent mflo read returns 0.
- multu: rs=0xFFFFFFFF, rt=0xFFFFFFFF → done in cycle 34, HI=0xFFFFFFFE, LO=0x00000001. busy high for exactly 33 cycles.
- mult: rs=0xFFFFFFFD (-3), rt=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- div with mixed signs:
  - rs=-7, rt=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - divu with rs=100, rt=7 → LO=14, HI=2.
- Divide boundaries:
  - div rs=0x12345678, rt=0 → LO=0xFFFFFFFF, HI=0x12345678.
  - div rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- Hazards:
  - mtlo rs=0xA5A5A5A5 → LO updated next cycle, busy never set.
  - hilo_sel=01 during busy → stall=1 and hilo_out shows the old LO.
  - start (mult) during busy → ignored; the original result is unchanged.
